// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle shared by the response producer, the TX byte FIFO and the
// UART transmitter; the FIFO is the slave, its environment the master.
interface uart_tx_fifo_if #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH_LOG2   = 4
);

  logic                    in_valid;
  logic [PAYLOAD_BITS-1:0] in_data;
  logic                    in_ready;
  logic                    out_en;
  logic [PAYLOAD_BITS-1:0] out_data;
  logic                    out_busy;
  logic [DEPTH_LOG2:0]     count;
  logic                    full;
  logic                    empty;
  logic                    overflow;

  modport master (
    output in_valid, in_data, out_busy,
    input  in_ready, out_en, out_data, count, full, empty, overflow
  );

  modport slave (
    input  in_valid, in_data, out_busy,
    output in_ready, out_en, out_data, count, full, empty, overflow
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer: buffers back-to-back response bytes and
// issues one single-cycle enable per byte once the transmitter is idle again.
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic          clk,
  input  logic          resetn,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     count;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    overflow;
  logic                    out_en;
  logic [PAYLOAD_BITS-1:0] out_data;

  // Flags come from the registered count, so a push on a full FIFO is
  // rejected even when a pop happens in the same cycle.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!empty && !bus.out_busy) state_next = WAIT_BUSY;
      WAIT_BUSY: if (bus.out_busy)            state_next = WAIT_DONE;
      WAIT_DONE: if (!bus.out_busy)           state_next = IDLE;
      default:                                state_next = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if ((state == IDLE) && !empty && !bus.out_busy) begin
      pop = 1'b1;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      out_en   <= 1'b0;
      out_data <= '0;
    end else begin
      out_en <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.in_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bus.in_ready = !full;
  assign bus.out_en   = out_en;
  assign bus.out_data = out_data;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based FIFO model plus a simple
// transmitter model, driven by table vectors, directed corner cases and random traffic.
module tb_uart_tx_fifo;

  localparam int PAYLOAD_BITS = 8;
  localparam int DEPTH_LOG2   = 4;
  localparam int DEPTH        = 1 << DEPTH_LOG2;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  int   tests    = 0;
  int   failures = 0;

  logic tx_auto;
  logic busy_manual;
  logic busy_model;
  int   tx_delay;
  int   tx_hold;
  int   busy_len;

  logic [7:0] fifo_q[$];
  logic       ovf_model;
  logic [7:0] last_data;
  logic       prev_en;
  int         pulses;
  int         max_count;

  uart_tx_fifo_if #(.PAYLOAD_BITS(PAYLOAD_BITS), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_tx_fifo #(.PAYLOAD_BITS(PAYLOAD_BITS), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  assign bus.out_busy = tx_auto ? busy_model : busy_manual;

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // One clock edge, then the transmitter model, scoreboard and flag checks.
  task automatic step();
    @(posedge clk);
    #1;
    if (tx_delay > 0) begin
      tx_delay--;
      if (tx_delay == 0) begin
        busy_model = 1'b1;
        tx_hold    = busy_len;
      end
    end else if (tx_hold > 0) begin
      tx_hold--;
      if (tx_hold == 0) busy_model = 1'b0;
    end
    if (!resetn) begin
      fifo_q.delete();
      ovf_model = 1'b0;
      last_data = 8'h00;
    end
    if (bus.out_en) begin
      if (prev_en) check_output("en_back_to_back", 32'(bus.out_en), 32'd0);
      if (fifo_q.size() == 0) begin
        check_output("launch_from_empty", 32'(bus.out_en), 32'd0);
      end else begin
        last_data = fifo_q.pop_front();
        check_output("out_data", 32'(bus.out_data), 32'(last_data));
      end
      pulses++;
      tx_delay = 1;
    end else begin
      check_output("out_data_held", 32'(bus.out_data), 32'(last_data));
    end
    prev_en = bus.out_en;
    check_output("count",    32'(bus.count),    32'(fifo_q.size()));
    check_output("full",     32'(bus.full),     32'(fifo_q.size() == DEPTH));
    check_output("empty",    32'(bus.empty),    32'(fifo_q.size() == 0));
    check_output("in_ready", 32'(bus.in_ready), 32'(fifo_q.size() != DEPTH));
    check_output("overflow", 32'(bus.overflow), 32'(ovf_model));
    if (int'(bus.count) > max_count) max_count = int'(bus.count);
  endtask

  task automatic apply_stimulus(input logic valid, input logic [7:0] data);
    bus.in_valid = valid;
    bus.in_data  = data;
    if (valid && resetn) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back(data);
      else ovf_model = 1'b1;
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || busy_model || tx_delay != 0) && n < budget) begin
      apply_stimulus(1'b0, 8'h00);
      n++;
    end
    check_output("drain_in_budget", 32'(fifo_q.size()), 32'd0);
    repeat (2) apply_stimulus(1'b0, 8'h00);
  endtask

  initial begin
    vec_t vecs[18];
    int   p;

    resetn       = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    tx_auto      = 1'b0;
    busy_manual  = 1'b0;
    busy_model   = 1'b0;
    tx_delay     = 0;
    tx_hold      = 0;
    busy_len     = 10;
    ovf_model    = 1'b0;
    last_data    = 8'h00;
    prev_en      = 1'b0;
    pulses       = 0;
    max_count    = 0;

    for (int i = 0; i < 17; i++) begin
      vecs[i] = '{1'b1, 8'(i), (i < 16) ? 5'(i + 1) : 5'd16, (i >= 15), (i >= 16)};
    end
    vecs[17] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b1};

    // Reset held with a push request pending.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("rst_out_en",   32'(bus.out_en),   32'd0);
    check_output("rst_out_data", 32'(bus.out_data), 32'd0);
    check_output("rst_count",    32'(bus.count),    32'd0);
    check_output("rst_full",     32'(bus.full),     32'd0);
    check_output("rst_empty",    32'(bus.empty),    32'd1);
    check_output("rst_overflow", 32'(bus.overflow), 32'd0);
    bus.in_valid = 1'b0;
    resetn       = 1'b1;
    repeat (2) apply_stimulus(1'b0, 8'h00);
    check_output("post_rst_count", 32'(bus.count), 32'd0);
    check_output("post_rst_empty", 32'(bus.empty), 32'd1);

    // Single byte: launch exactly one edge after the push.
    tx_auto  = 1'b1;
    busy_len = 10;
    p        = pulses;
    apply_stimulus(1'b1, 8'hA5);
    check_output("single_no_early_en", 32'(bus.out_en), 32'd0);
    check_output("single_count_push",  32'(bus.count),  32'd1);
    apply_stimulus(1'b0, 8'h00);
    check_output("single_en",       32'(bus.out_en),   32'd1);
    check_output("single_data",     32'(bus.out_data), 32'hA5);
    check_output("single_count_0",  32'(bus.count),    32'd0);
    apply_stimulus(1'b0, 8'h00);
    check_output("single_en_low",   32'(bus.out_en),   32'd0);
    repeat (15) apply_stimulus(1'b0, 8'h00);
    check_output("single_one_pulse", 32'(pulses - p), 32'd1);
    drain(100);

    // Fill and overflow from the vector table with the transmitter held busy.
    tx_auto     = 1'b0;
    busy_manual = 1'b1;
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].data);
      check_output("vec_count",    32'(bus.count),    32'(vecs[i].exp_count));
      check_output("vec_full",     32'(bus.full),     32'(vecs[i].exp_full));
      check_output("vec_overflow", 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      check_output("vec_in_ready", 32'(bus.in_ready), 32'(!vecs[i].exp_full));
    end
    p       = pulses;
    tx_auto = 1'b1;
    drain(400);
    check_output("fill_pulses",    32'(pulses - p),   32'd16);
    check_output("fill_empty",     32'(bus.empty),    32'd1);
    check_output("fill_ovf_stays", 32'(bus.overflow), 32'd1);

    // Wrap-around: 40 bytes in bursts of 5.
    busy_len  = 3;
    max_count = 0;
    p         = pulses;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 5; k++) apply_stimulus(1'b1, 8'($urandom));
      drain(200);
    end
    check_output("wrap_pulses",    32'(pulses - p),    32'd40);
    check_output("wrap_max_le5",   32'(max_count <= 5), 32'd1);

    // Push in the same cycle as a launch, count=3.
    tx_auto     = 1'b0;
    busy_manual = 1'b1;
    for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 8'(8'h60 + k));
    check_output("sim3_count_before", 32'(bus.count), 32'd3);
    busy_manual = 1'b0;
    apply_stimulus(1'b1, 8'h77);
    check_output("sim3_launch", 32'(bus.out_en), 32'd1);
    check_output("sim3_count",  32'(bus.count),  32'd3);
    tx_auto = 1'b1;
    drain(300);

    // Same with a full FIFO: push rejected, count drops to 15.
    tx_auto     = 1'b0;
    busy_manual = 1'b1;
    for (int k = 0; k < 16; k++) apply_stimulus(1'b1, 8'(8'h80 + k));
    check_output("sim16_full", 32'(bus.full), 32'd1);
    busy_manual = 1'b0;
    apply_stimulus(1'b1, 8'hEE);
    check_output("sim16_launch",   32'(bus.out_en),   32'd1);
    check_output("sim16_count",    32'(bus.count),    32'd15);
    check_output("sim16_overflow", 32'(bus.overflow), 32'd1);
    tx_auto = 1'b1;
    drain(400);

    // Reset while waiting for the transmitter with 4 bytes queued.
    busy_len = 10;
    for (int k = 0; k < 5; k++) apply_stimulus(1'b1, 8'(8'h40 + k));
    check_output("mid_count_before", 32'(bus.count), 32'd4);
    resetn = 1'b0;
    fifo_q.delete();
    ovf_model = 1'b0;
    last_data = 8'h00;
    #1;
    check_output("mid_async_count", 32'(bus.count),    32'd0);
    check_output("mid_async_empty", 32'(bus.empty),    32'd1);
    check_output("mid_async_ovf",   32'(bus.overflow), 32'd0);
    check_output("mid_async_data",  32'(bus.out_data), 32'd0);
    repeat (2) apply_stimulus(1'b0, 8'h00);
    resetn = 1'b1;
    p      = pulses;
    repeat (20) apply_stimulus(1'b0, 8'h00);
    check_output("mid_no_pulse", 32'(pulses - p), 32'd0);
    apply_stimulus(1'b1, 8'h3C);
    check_output("mid_new_no_early", 32'(bus.out_en), 32'd0);
    apply_stimulus(1'b0, 8'h00);
    check_output("mid_new_en",   32'(bus.out_en),   32'd1);
    check_output("mid_new_data", 32'(bus.out_data), 32'h3C);
    drain(100);

    // Random traffic at varying push rates and transmitter speeds.
    for (int blk = 0; blk < 6; blk++) begin
      int rate;
      rate = (blk % 3 == 0) ? 15 : ((blk % 3 == 1) ? 50 : 95);
      for (int c = 0; c < 100; c++) begin
        if (c % 10 == 0) busy_len = int'($urandom_range(1, 6));
        apply_stimulus(($urandom_range(0, 99) < rate), 8'($urandom));
      end
    end
    drain(1000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
